// File: rtl/greyhound_qspi_pkg.sv
// Shared types and constants for the greyhound QSPI flash read controller.
package greyhound_qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_MODE  = 3'd3,
        ST_DUMMY = 3'd4,
        ST_DATA  = 3'd5,
        ST_CSH   = 3'd6
    } qspi_state_e;

    localparam logic [7:0] QSPI_CMD_QREAD  = 8'hEB;
    localparam logic [7:0] QSPI_MODE_BYTE  = 8'hF0;

    localparam logic [4:0] CMD_SCK_CYCLES  = 5'd8;
    localparam logic [4:0] ADDR_SCK_CYCLES = 5'd6;
    localparam logic [4:0] MODE_SCK_CYCLES = 5'd2;
    localparam logic [4:0] DATA_SCK_CYCLES = 5'd8;

    // Nibbles arrive byte 0 first, so byte 0 sits in the top of the assembly register.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/greyhound_qspi_flash_ctrl.sv
// Single-word Quad I/O Fast Read (0xEB) controller: one 24-bit address in,
// one little-endian 32-bit word out, SPI mode 0 with SCK at clk/2.
module greyhound_qspi_flash_ctrl
    import greyhound_qspi_pkg::*;
#(
    parameter int DUMMY_CYCLES   = 4,
    parameter int CS_HIGH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [23:0] addr_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        flash_sck,
    output logic        flash_ce_n,
    output logic [3:0]  flash_dout,
    output logic [3:0]  flash_douten,
    input  logic [3:0]  flash_din
);

    qspi_state_e state_r, state_nxt_s;
    logic        phase_r, phase_nxt_s;
    logic [4:0]  cnt_r, cnt_nxt_s;
    logic [31:0] sreg_r, sreg_nxt_s;
    logic [31:0] rx_r, rx_nxt_s;
    logic        sck_r, sck_nxt_s;
    logic        ce_n_r, ce_n_nxt_s;
    logic [3:0]  dout_r, dout_nxt_s;
    logic [3:0]  douten_r, douten_nxt_s;
    logic        rvalid_r, rvalid_nxt_s;
    logic [31:0] rdata_r, rdata_nxt_s;
    logic        ready_r, ready_nxt_s;

    logic [31:0] sreg_sh1_s, sreg_sh4_s, rx_sh_s;
    logic        last_s;

    assign sreg_sh1_s = {sreg_r[30:0], 1'b0};
    assign sreg_sh4_s = {sreg_r[27:0], 4'b0000};
    assign rx_sh_s    = {rx_r[27:0], flash_din};
    assign last_s     = (cnt_r == 5'd0);

    // State and all pad/port outputs are registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            phase_r  <= 1'b0;
            cnt_r    <= 5'd0;
            sreg_r   <= 32'd0;
            rx_r     <= 32'd0;
            sck_r    <= 1'b0;
            ce_n_r   <= 1'b1;
            dout_r   <= 4'd0;
            douten_r <= 4'd0;
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            ready_r  <= 1'b1;
        end else begin
            state_r  <= state_nxt_s;
            phase_r  <= phase_nxt_s;
            cnt_r    <= cnt_nxt_s;
            sreg_r   <= sreg_nxt_s;
            rx_r     <= rx_nxt_s;
            sck_r    <= sck_nxt_s;
            ce_n_r   <= ce_n_nxt_s;
            dout_r   <= dout_nxt_s;
            douten_r <= douten_nxt_s;
            rvalid_r <= rvalid_nxt_s;
            rdata_r  <= rdata_nxt_s;
            ready_r  <= ready_nxt_s;
        end
    end

    // Next-state and next-output logic; the bus only advances on the edge ending phase B.
    always_comb begin
        state_nxt_s  = state_r;
        phase_nxt_s  = phase_r;
        cnt_nxt_s    = cnt_r;
        sreg_nxt_s   = sreg_r;
        rx_nxt_s     = rx_r;
        sck_nxt_s    = sck_r;
        ce_n_nxt_s   = ce_n_r;
        dout_nxt_s   = dout_r;
        douten_nxt_s = douten_r;
        rvalid_nxt_s = 1'b0;
        rdata_nxt_s  = rdata_r;
        ready_nxt_s  = ready_r;

        case (state_r)
            ST_IDLE: begin
                if (req_i && ready_r) begin
                    state_nxt_s  = ST_CMD;
                    phase_nxt_s  = 1'b0;
                    cnt_nxt_s    = CMD_SCK_CYCLES - 5'd1;
                    sreg_nxt_s   = {QSPI_CMD_QREAD, addr_i};
                    sck_nxt_s    = 1'b0;
                    ce_n_nxt_s   = 1'b0;
                    dout_nxt_s   = {3'b000, QSPI_CMD_QREAD[7]};
                    douten_nxt_s = 4'b0001;
                    ready_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_CSH: begin
                if (last_s) begin
                    state_nxt_s = ST_IDLE;
                    ready_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r - 5'd1;
                end
            end
            ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA: begin
                if (!phase_r) begin
                    sck_nxt_s   = 1'b1;
                    phase_nxt_s = 1'b1;
                end else begin
                    sck_nxt_s   = 1'b0;
                    phase_nxt_s = 1'b0;
                    cnt_nxt_s   = cnt_r - 5'd1;
                    case (state_r)
                        ST_CMD: begin
                            sreg_nxt_s = sreg_sh1_s;
                            if (last_s) begin
                                state_nxt_s  = ST_ADDR;
                                cnt_nxt_s    = ADDR_SCK_CYCLES - 5'd1;
                                dout_nxt_s   = sreg_sh1_s[31:28];
                                douten_nxt_s = 4'b1111;
                            end else begin
                                dout_nxt_s   = {3'b000, sreg_sh1_s[31]};
                            end
                        end
                        ST_ADDR: begin
                            sreg_nxt_s = sreg_sh4_s;
                            if (last_s) begin
                                state_nxt_s = ST_MODE;
                                cnt_nxt_s   = MODE_SCK_CYCLES - 5'd1;
                                dout_nxt_s  = QSPI_MODE_BYTE[7:4];
                            end else begin
                                dout_nxt_s  = sreg_sh4_s[31:28];
                            end
                        end
                        ST_MODE: begin
                            if (last_s) begin
                                state_nxt_s  = ST_DUMMY;
                                cnt_nxt_s    = 5'(DUMMY_CYCLES - 1);
                                dout_nxt_s   = 4'b0000;
                                douten_nxt_s = 4'b0000;
                            end else begin
                                dout_nxt_s   = QSPI_MODE_BYTE[3:0];
                            end
                        end
                        ST_DUMMY: begin
                            if (last_s) begin
                                state_nxt_s = ST_DATA;
                                cnt_nxt_s   = DATA_SCK_CYCLES - 5'd1;
                            end else begin
                                state_nxt_s = ST_DUMMY;
                            end
                        end
                        ST_DATA: begin
                            rx_nxt_s = rx_sh_s;
                            if (last_s) begin
                                state_nxt_s  = ST_CSH;
                                cnt_nxt_s    = 5'(CS_HIGH_CYCLES - 1);
                                ce_n_nxt_s   = 1'b1;
                                rvalid_nxt_s = 1'b1;
                                rdata_nxt_s  = byte_swap32(rx_sh_s);
                            end else begin
                                state_nxt_s  = ST_DATA;
                            end
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                phase_nxt_s  = 1'b0;
                sck_nxt_s    = 1'b0;
                ce_n_nxt_s   = 1'b1;
                dout_nxt_s   = 4'b0000;
                douten_nxt_s = 4'b0000;
                ready_nxt_s  = 1'b1;
            end
        endcase
    end

    assign ready_o      = ready_r;
    assign rvalid_o     = rvalid_r;
    assign rdata_o      = rdata_r;
    assign flash_sck    = sck_r;
    assign flash_ce_n   = ce_n_r;
    assign flash_dout   = dout_r;
    assign flash_douten = douten_r;

endmodule

// File: tb/tb_greyhound_qspi_flash_ctrl.sv
// Self-checking bench: behavioural flash device plus a cycle-level transaction model.
module tb_greyhound_qspi_flash_ctrl;

    localparam int DUMMY = 4;
    localparam int CSH   = 2;
    localparam int N     = 2 * (24 + DUMMY);
    localparam int D6    = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic [23:0] addr = 24'd0;
    logic        ready_o, rvalid_o, flash_sck, flash_ce_n;
    logic [31:0] rdata_o;
    logic [3:0]  flash_dout, flash_douten;
    logic [3:0]  flash_din = 4'd0;

    logic        rst6_n = 1'b1;
    logic        req6 = 1'b0;
    logic [23:0] addr6 = 24'd0;
    logic        ready6, rvalid6, sck6, ce6_n;
    logic [31:0] rdata6;
    logic [3:0]  dout6, douten6;
    logic [3:0]  din6 = 4'd0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    greyhound_qspi_flash_ctrl #(.DUMMY_CYCLES(DUMMY), .CS_HIGH_CYCLES(CSH)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr),
        .ready_o(ready_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .flash_sck(flash_sck), .flash_ce_n(flash_ce_n), .flash_dout(flash_dout),
        .flash_douten(flash_douten), .flash_din(flash_din));

    greyhound_qspi_flash_ctrl #(.DUMMY_CYCLES(D6), .CS_HIGH_CYCLES(CSH)) u_dut6 (
        .clk_i(clk), .rst_ni(rst6_n), .req_i(req6), .addr_i(addr6),
        .ready_o(ready6), .rvalid_o(rvalid6), .rdata_o(rdata6),
        .flash_sck(sck6), .flash_ce_n(ce6_n), .flash_dout(dout6),
        .flash_douten(douten6), .flash_din(din6));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flash contents: explicit bytes where written, an address-derived pattern elsewhere.
    logic [7:0] mem [logic [23:0]];

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {mem_byte(a + 24'd3), mem_byte(a + 24'd2), mem_byte(a + 24'd1), mem_byte(a)};
    endfunction

    function automatic logic [3:0] nib(input logic [23:0] a, input int j);
        logic [7:0] b;
        b = mem_byte(a + 24'(j / 2));
        return (j % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: k counts edges since the accepting edge.
    logic        m_active = 1'b0;
    int          m_k = 0;
    logic [23:0] m_addr = 24'd0;
    logic [31:0] m_rdata = 32'd0;
    int          m_acc_n = 0;
    int          m_acc_cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_rdata  <= 32'd0;
        end else if (m_active) begin
            m_k <= m_k + 1;
            if (m_k == N + CSH - 1) m_active <= 1'b0;
            if (m_k + 1 == N) m_rdata <= exp_word(m_addr);
        end else if (req) begin
            m_active  <= 1'b1;
            m_k       <= 0;
            m_addr    <= addr;
            m_acc_n   <= m_acc_n + 1;
            m_acc_cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic       e_ce, e_sck, e_rdy, e_rv;
            logic [3:0] e_oe;
            if (m_active && m_k < N) begin
                e_ce  = 1'b0;
                e_sck = (m_k % 2) == 1;
                e_oe  = (m_k < 16) ? 4'b0001 : (m_k < 32) ? 4'b1111 : 4'b0000;
                e_rdy = 1'b0;
            end else begin
                e_ce  = 1'b1;
                e_sck = 1'b0;
                e_oe  = 4'b0000;
                e_rdy = !m_active;
            end
            e_rv = m_active && (m_k == N);
            chk("ce_n", 32'(flash_ce_n), 32'(e_ce));
            chk("sck", 32'(flash_sck), 32'(e_sck));
            chk("douten", 32'(flash_douten), 32'(e_oe));
            chk("ready", 32'(ready_o), 32'(e_rdy));
            chk("rvalid", 32'(rvalid_o), 32'(e_rv));
            chk("rdata", rdata_o, m_rdata);
        end
    end

    // Flash device for the default instance: decodes command/address/mode on rising SCK.
    int          f_rise = 0;
    logic [23:0] f_addr = 24'd0;
    logic [7:0]  cmd_ref = 8'hEB;
    logic [7:0]  mode_ref = 8'hF0;

    always @(posedge flash_sck or negedge flash_ce_n) begin
        if (!flash_sck) begin
            f_rise = 0;
        end else begin
            if (f_rise < 8) chk("cmd_bit", 32'(flash_dout), 32'(cmd_ref[7 - f_rise]));
            else if (f_rise < 14) f_addr = {f_addr[19:0], flash_dout};
            else if (f_rise < 16) chk("mode_nib", 32'(flash_dout),
                                      32'((f_rise == 14) ? mode_ref[7:4] : mode_ref[3:0]));
            if (f_rise == 14) chk("addr_bus", 32'(f_addr), 32'(m_addr));
            f_rise = f_rise + 1;
        end
    end

    always @(negedge flash_sck) begin
        if (!flash_ce_n && f_rise >= 16 + DUMMY && f_rise < 24 + DUMMY)
            flash_din = nib(f_addr, f_rise - 16 - DUMMY);
    end

    int          f6_rise = 0;
    logic [23:0] f6_addr = 24'd0;

    always @(posedge sck6 or negedge ce6_n) begin
        if (!sck6) begin
            f6_rise = 0;
        end else begin
            if (f6_rise >= 8 && f6_rise < 14) f6_addr = {f6_addr[19:0], dout6};
            f6_rise = f6_rise + 1;
        end
    end

    always @(negedge sck6) begin
        if (!ce6_n && f6_rise >= 16 + D6 && f6_rise < 24 + D6) begin
            din6 = nib(f6_addr, f6_rise - 16 - D6);
            chk("douten6_data", 32'(douten6), 32'd0);
        end
    end

    task automatic wait_accept(output int acc);
        int  n0;
        bit  ok;
        n0 = m_acc_n;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (m_acc_n != n0) ok = 1'b1;
        end
        chk("accept_seen", 32'(ok), 32'd1);
        acc = m_acc_cyc;
    endtask

    task automatic do_read(input logic [23:0] a, output logic [31:0] rd,
                           output int lat, output int rdy_lat);
        int acc;
        bit ok;
        @(negedge clk);
        req = 1'b1;
        addr = a;
        wait_accept(acc);
        req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (rvalid_o) ok = 1'b1;
        end
        chk("rvalid_seen", 32'(ok), 32'd1);
        rd = rdata_o;
        lat = cyc - acc;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (ready_o) ok = 1'b1;
        end
        chk("ready_seen", 32'(ok), 32'd1);
        rdy_lat = cyc - acc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat, rl, acc1, acc2;
        bit          ok;

        #1;
        rst_n = 1'b0;
        rst6_n = 1'b0;
        #1;
        chk("rst_ce_n", 32'(flash_ce_n), 32'd1);
        chk("rst_sck", 32'(flash_sck), 32'd0);
        chk("rst_dout", 32'(flash_dout), 32'd0);
        chk("rst_douten", 32'(flash_douten), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rst6_n = 1'b1;

        mem[24'h000100] = 8'h44; mem[24'h000101] = 8'h33;
        mem[24'h000102] = 8'h22; mem[24'h000103] = 8'h11;
        do_read(24'h000100, rd, lat, rl);
        chk("t1_data", rd, 32'h11223344);
        chk("t1_rvalid_lat", 32'(lat), 32'd56);
        chk("t1_ready_lat", 32'(rl), 32'd58);
        chk("t1_addr_nibbles", 32'(f_addr), 32'h00000100);

        mem[24'h000FFF] = 8'hAA; mem[24'h001000] = 8'hBB; mem[24'h001001] = 8'hCC;
        mem[24'h001002] = 8'hDD; mem[24'h001003] = 8'hEE;
        do_read(24'h000FFF, rd, lat, rl);
        chk("unaligned_data", rd, 32'hDDCCBBAA);

        for (int i = 0; i < 8; i++) begin
            mem[24'(i)] = 8'(i + 1);
        end
        @(negedge clk);
        req = 1'b1;
        addr = 24'h000000;
        wait_accept(acc1);
        addr = 24'h000004;
        wait_accept(acc2);
        req = 1'b0;
        chk("held_spacing", 32'(acc2 - acc1), 32'd59);
        chk("held_first_word_kept", rdata_o, 32'h04030201);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (rvalid_o) ok = 1'b1;
        end
        chk("held_rvalid2", 32'(ok), 32'd1);
        chk("held_second_word", rdata_o, 32'h08070605);
        repeat (4) @(negedge clk);

        @(negedge clk);
        req = 1'b1;
        addr = 24'h000100;
        wait_accept(acc1);
        req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (m_k >= 2 * (16 + DUMMY) + 5) ok = 1'b1;
        end
        chk("reached_data_phase", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ce_n", 32'(flash_ce_n), 32'd1);
        chk("arst_sck", 32'(flash_sck), 32'd0);
        chk("arst_douten", 32'(flash_douten), 32'd0);
        chk("arst_rdata", rdata_o, 32'd0);
        chk("arst_rvalid", 32'(rvalid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        do_read(24'h000100, rd, lat, rl);
        chk("after_rst_data", rd, 32'h11223344);

        for (int t = 0; t < 10; t++) begin
            logic [23:0] a;
            a = 24'($urandom);
            if (t % 2 == 0) begin
                for (int b = 0; b < 4; b++) mem[a + 24'(b)] = 8'($urandom);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_read(a, rd, lat, rl);
            chk("rand_data", rd, exp_word(a));
            chk("rand_lat", 32'(lat), 32'(N));
            chk("rand_ready_lat", 32'(rl), 32'(N + CSH));
        end

        @(negedge clk);
        chk("dut6_idle", 32'(ready6), 32'd1);
        req6 = 1'b1;
        addr6 = 24'h000100;
        @(posedge clk); #1;
        acc1 = cyc;
        req6 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (rvalid6) ok = 1'b1;
        end
        chk("dut6_rvalid_seen", 32'(ok), 32'd1);
        chk("dut6_lat", 32'(cyc - acc1), 32'(2 * (24 + D6)));
        chk("dut6_lat_lit", 32'(cyc - acc1), 32'd60);
        chk("dut6_data", rdata6, 32'h11223344);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
